// File: rtl/alarm_clk_seg_display.sv
// alarm_clk_seg_display
//   Seven-segment display stage for the alarm clock. Registers the six BCD
//   digits coming from the PIO slaves, decodes them (10-15 show a dash),
//   optionally blanks digits for a blink effect, and drives six registered
//   HEX outputs.
//
//   Optional feature macro: ALARM_CLK_BLINK_EN
//     defined   : blink prescaler, restart logic and digit blanking built in
//     undefined : edit_sel / alarm_ring ignored, digits never blanked
//
// Ports
//   clk                     system clock (same as the PIO slaves)
//   reset                   asynchronous, active-high reset
//   h1,h0,m1,m0,s1,s0 [3:0] BCD digits
//   edit_sel [2:0]          digit to blink: 1=s0 .. 6=h1, 0/7 = none
//   alarm_ring              level; while high every digit blinks
//   hex0..hex5 [6:0]        segments g..a, hex0=s0 .. hex5=h1
module alarm_clk_seg_display #(
    parameter int CLK_HZ     = 50000000,
    parameter int BLINK_HZ   = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] h1,
    input  logic [3:0] h0,
    input  logic [3:0] m1,
    input  logic [3:0] m0,
    input  logic [3:0] s1,
    input  logic [3:0] s0,
    input  logic [2:0] edit_sel,
    input  logic       alarm_ring,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5
);

    // Cycles per visible (or blanked) half of one blink period.
    localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;

    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h40;   // invalid BCD shows a dash
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] apply_polarity(input logic [6:0] seg);
        return ACTIVE_LOW ? ~seg : seg;
    endfunction

    // ---- capture stage (p0) ----
    logic [3:0] dig_p0 [6];   // index 0 = s0 .. 5 = h1

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) dig_p0[i] <= 4'd0;
        end else begin
            dig_p0[0] <= s0;
            dig_p0[1] <= s1;
            dig_p0[2] <= m0;
            dig_p0[3] <= m1;
            dig_p0[4] <= h0;
            dig_p0[5] <= h1;
        end
    end

    logic [5:0] blank;

`ifdef ALARM_CLK_BLINK_EN
    localparam int              CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [2:0]       sel_p0;
    logic [2:0]       sel_prev;
    logic             ring_p0;
    logic             ring_prev;
    logic [CNT_W-1:0] cnt;
    logic             blink_phase;
    logic             restart;
    logic [CNT_W-1:0] cnt_eff;
    logic             phase_eff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_p0    <= 3'd0;
            sel_prev  <= 3'd0;
            ring_p0   <= 1'b0;
            ring_prev <= 1'b0;
        end else begin
            sel_p0    <= edit_sel;
            sel_prev  <= sel_p0;
            ring_p0   <= alarm_ring;
            ring_prev <= ring_p0;
        end
    end

    // A new selection or a fresh alarm restarts the blink so the affected
    // digits start visible. The restart cycle itself already sees the
    // cleared count/phase, so the first visible half lasts a full HALF.
    always_comb begin
        restart   = (sel_p0 != sel_prev) | (ring_p0 & ~ring_prev);
        cnt_eff   = restart ? '0 : cnt;
        phase_eff = restart ? 1'b0 : blink_phase;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            blink_phase <= 1'b0;
        end else if (cnt_eff == CNT_LAST) begin
            cnt         <= '0;
            blink_phase <= ~phase_eff;
        end else begin
            cnt         <= cnt_eff + CNT_W'(1);
            blink_phase <= phase_eff;
        end
    end

    // alarm_ring blanks everything, so it naturally overrides edit_sel.
    always_comb begin
        blank = '0;
        for (int j = 0; j < 6; j++) begin
            blank[j] = phase_eff & (ring_p0 | (sel_p0 == 3'(j + 1)));
        end
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = ^{edit_sel, alarm_ring, HALF[0]};
    assign blank       = '0;
`endif

    // ---- output stage (p1) ----
    logic [6:0] seg_p1 [6];

    always_comb begin
        for (int j = 0; j < 6; j++) begin
            seg_p1[j] = blank[j] ? SEG_OFF : apply_polarity(bcd_to_seg(dig_p0[j]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex0 <= SEG_OFF;
            hex1 <= SEG_OFF;
            hex2 <= SEG_OFF;
            hex3 <= SEG_OFF;
            hex4 <= SEG_OFF;
            hex5 <= SEG_OFF;
        end else begin
            hex0 <= seg_p1[0];
            hex1 <= seg_p1[1];
            hex2 <= seg_p1[2];
            hex3 <= seg_p1[3];
            hex4 <= seg_p1[4];
            hex5 <= seg_p1[5];
        end
    end

endmodule

// File: tb/tb_alarm_clk_seg_display.sv
// Testbench for alarm_clk_seg_display (CLK_HZ=8, BLINK_HZ=1 -> HALF=4,
// ACTIVE_LOW=1). Stimulus pushes the expected hex pattern for a given clock
// edge into a scoreboard queue; a monitor checks entries on the falling edge.
module tb_alarm_clk_seg_display;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] h1 = 4'd0, h0 = 4'd0, m1 = 4'd0, m0 = 4'd0, s1 = 4'd0, s0 = 4'd0;
    logic [2:0] edit_sel = 3'd0;
    logic       alarm_ring = 1'b0;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

`ifdef ALARM_CLK_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [6:0] OFF  = 7'h7F;
    localparam logic [6:0] ZERO = 7'h40;
    localparam logic [6:0] ONE  = 7'h79;

    // Active-low decode of 0..15 (dash for 10..15).
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    alarm_clk_seg_display #(
        .CLK_HZ     (8),
        .BLINK_HZ   (1),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .h1         (h1),
        .h0         (h0),
        .m1         (m1),
        .m0         (m0),
        .s1         (s1),
        .s0         (s0),
        .edit_sel   (edit_sel),
        .alarm_ring (alarm_ring),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        logic [41:0] exp;    // {hex5,hex4,hex3,hex2,hex1,hex0}
        logic [5:0]  mask;
        string       name;
    } sb_t;

    sb_t sb [$];

    task automatic push(input int c, input logic [41:0] e, input logic [5:0] m, input string n);
        sb_t t;
        t.cyc  = c;
        t.exp  = e;
        t.mask = m;
        t.name = n;
        sb.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: check every entry due at the current edge count.
    initial begin
        sb_t         cur;
        logic [41:0] act;
        logic [5:0]  diff;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                cur = sb.pop_front();
                total++;
                act = {hex5, hex4, hex3, hex2, hex1, hex0};
                if (cur.cyc != edge_cnt) begin
                    bad++;
                    $display("FAIL %s: check for cycle %0d skipped, now cycle %0d",
                             cur.name, cur.cyc, edge_cnt);
                end else begin
                    diff = '0;
                    for (int j = 0; j < 6; j++)
                        if (cur.mask[j] && act[7*j +: 7] !== cur.exp[7*j +: 7]) diff[j] = 1'b1;
                    if (diff != 6'd0) begin
                        bad++;
                        $display("FAIL %s @cycle %0d: hex5..hex0 got %h %h %h %h %h %h, want %h %h %h %h %h %h",
                                 cur.name, edge_cnt,
                                 act[41:35], act[34:28], act[27:21], act[20:14], act[13:7], act[6:0],
                                 cur.exp[41:35], cur.exp[34:28], cur.exp[27:21],
                                 cur.exp[20:14], cur.exp[13:7], cur.exp[6:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, u, v, w, x;
        logic [41:0] vis, blk, e;
        vis = {ONE, ZERO, ZERO, ZERO, ZERO, ZERO};
        blk = {6{OFF}};

        // Reset: all segments off, then decoded zeros after release.
        step();
        step();
        push(edge_cnt, blk, 6'h3F, "reset_off");
        step();
        reset = 1'b0;
        push(edge_cnt + 2, {6{ZERO}}, 6'h3F, "reset_release");
        step();

        // Decode sweep on s0.
        for (int d = 0; d < 16; d++) begin
            s0 = 4'(d);
            push(edge_cnt + 2, {ZERO, ZERO, ZERO, ZERO, ZERO, seg_tbl[d]}, 6'h3F, "decode");
            step();
        end

        // Edit blink on h1.
        s0 = 4'd0;
        h1 = 4'd1;
        edit_sel = 3'd6;
        t = edge_cnt;
        for (int k = 0; k < 16; k++) begin
            e = (BLINK && (k % 8) >= 4) ? {OFF, ZERO, ZERO, ZERO, ZERO, ZERO} : vis;
            push(t + 2 + k, e, 6'h3F, "edit_blink");
        end
        repeat (16) step();

        // Restart: hex5 is blanked now; move selection to m0.
        u = edge_cnt;
        edit_sel = 3'd3;
        for (int k = 0; k < 8; k++) begin
            e = {ONE, ZERO, ZERO, (BLINK && k >= 4) ? OFF : ZERO, ZERO, ZERO};
            push(u + 2 + k, e, 6'h3F, "restart");
        end
        repeat (8) step();

        // Alarm: every digit blinks together.
        v = edge_cnt;
        edit_sel = 3'd0;
        alarm_ring = 1'b1;
        for (int k = 0; k < 14; k++) begin
            e = (BLINK && (k % 8) >= 4) ? blk : vis;
            push(v + 2 + k, e, 6'h3F, "alarm");
        end
        repeat (14) step();

        // Drop alarm while blanked: no blanking from 3 cycles on.
        w = edge_cnt;
        alarm_ring = 1'b0;
        for (int k = 3; k <= 10; k++) push(w + k, vis, 6'h3F, "alarm_drop");
        repeat (11) step();

        // Re-raise alarm, then reset while blanked.
        x = edge_cnt;
        alarm_ring = 1'b1;
        for (int k = 2; k <= 5; k++) push(x + k, vis, 6'h3F, "alarm_again");
        repeat (6) step();
        reset = 1'b1;
        push(edge_cnt, blk, 6'h3F, "reset_mid");
        step();
        push(edge_cnt, blk, 6'h3F, "reset_hold");
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e = (BLINK && k >= 4) ? blk : vis;
            push(x + 9 + k, e, 6'h3F, "after_reset");
        end
        repeat (8) step();

        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks still pending, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
